// File: rtl/pbit_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pbit_sweep_ctrl_if
//  Brief    : Host-command and LFSR/p-bit strobe bundle for pbit_sweep_ctrl.
//  Revision : 1.0
// ============================================================================
interface pbit_sweep_ctrl_if #(
    parameter int IDX_W  = 4,
    parameter int LFSR_W = 12
);
    logic              start;
    logic              abort;
    logic [15:0]       num_sweeps;
    logic [LFSR_W-1:0] seed;
    logic              lfsr_load;
    logic [LFSR_W-1:0] lfsr_seed;
    logic              lfsr_en;
    logic              pbit_update;
    logic [IDX_W-1:0]  pbit_sel;
    logic [15:0]       sweep_cnt;
    logic              busy;
    logic              done;

    modport master (
        output start, abort, num_sweeps, seed,
        input  lfsr_load, lfsr_seed, lfsr_en, pbit_update, pbit_sel,
               sweep_cnt, busy, done
    );

    modport slave (
        input  start, abort, num_sweeps, seed,
        output lfsr_load, lfsr_seed, lfsr_en, pbit_update, pbit_sel,
               sweep_cnt, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/pbit_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pbit_sweep_ctrl
//  Brief    : Seeds a shared LFSR, lets it settle, then strobes p-bit updates
//             round-robin for a programmed number of Gibbs sweeps.
//  Revision : 1.0
// ============================================================================
module pbit_sweep_ctrl #(
    parameter int N_PBITS    = 16,
    parameter int IDX_W      = 4,
    parameter int LFSR_W     = 12,
    parameter int SETTLE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic               clk,
    input  logic               rst,
    pbit_sweep_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_UPDATE = 3'd3,
        S_HOLD   = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    // One down-counter serves both the settle and hold intervals.
    localparam int                 c_CNT_MAX   = (SETTLE_CYC > HOLD_CYC) ? SETTLE_CYC : HOLD_CYC;
    localparam int                 c_CNT_W     = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_SETTLE_LD = c_CNT_W'(SETTLE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LD   = c_CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
    localparam logic [IDX_W-1:0]   c_LAST_SEL  = IDX_W'(N_PBITS - 1);
    localparam bit                 c_NO_HOLD   = (HOLD_CYC == 0);

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [15:0]        r_num;
    logic               r_lfsr_load;
    logic [LFSR_W-1:0]  r_lfsr_seed;
    logic               r_lfsr_en;
    logic               r_pbit_update;
    logic [IDX_W-1:0]   r_pbit_sel;
    logic [15:0]        r_sweep_cnt;
    logic               r_busy;
    logic               r_done;

    logic               w_advance;
    logic               w_last_sel;
    logic [15:0]        w_sweep_inc;

    assign w_advance   = ((r_state == S_UPDATE) && c_NO_HOLD) ||
                         ((r_state == S_HOLD) && (r_cnt == '0));
    assign w_last_sel  = (r_pbit_sel == c_LAST_SEL);
    assign w_sweep_inc = r_sweep_cnt + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_num         <= '0;
            r_lfsr_load   <= 1'b0;
            r_lfsr_seed   <= '0;
            r_lfsr_en     <= 1'b0;
            r_pbit_update <= 1'b0;
            r_pbit_sel    <= '0;
            r_sweep_cnt   <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else if (bus.abort && (r_state != S_IDLE)) begin
            r_state       <= S_IDLE;
            r_lfsr_load   <= 1'b0;
            r_lfsr_en     <= 1'b0;
            r_pbit_update <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_num       <= bus.num_sweeps;
                        r_lfsr_seed <= bus.seed;
                        r_sweep_cnt <= '0;
                        r_pbit_sel  <= '0;
                        r_busy      <= 1'b1;
                        if (bus.num_sweeps == 16'd0) begin
                            r_state <= S_FINISH;
                            r_done  <= 1'b1;
                        end else begin
                            r_state     <= S_LOAD;
                            r_lfsr_load <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    r_lfsr_load <= 1'b0;
                    r_lfsr_en   <= 1'b1;
                    r_cnt       <= c_SETTLE_LD;
                    r_state     <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_cnt == '0) begin
                        r_state       <= S_UPDATE;
                        r_pbit_update <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                S_UPDATE, S_HOLD: begin
                    r_pbit_update <= 1'b0;
                    if (w_advance) begin
                        if (w_last_sel) begin
                            // Sweep boundary: wrap the index and decide whether the run is over.
                            r_pbit_sel  <= '0;
                            r_sweep_cnt <= w_sweep_inc;
                            if (w_sweep_inc == r_num) begin
                                r_state   <= S_FINISH;
                                r_done    <= 1'b1;
                                r_lfsr_en <= 1'b0;
                            end else begin
                                r_state       <= S_UPDATE;
                                r_pbit_update <= 1'b1;
                            end
                        end else begin
                            r_pbit_sel    <= r_pbit_sel + IDX_W'(1);
                            r_state       <= S_UPDATE;
                            r_pbit_update <= 1'b1;
                        end
                    end else if (r_state == S_UPDATE) begin
                        r_state <= S_HOLD;
                        r_cnt   <= c_HOLD_LD;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                S_FINISH: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.lfsr_load   = r_lfsr_load;
    assign bus.lfsr_seed   = r_lfsr_seed;
    assign bus.lfsr_en     = r_lfsr_en;
    assign bus.pbit_update = r_pbit_update;
    assign bus.pbit_sel    = r_pbit_sel;
    assign bus.sweep_cnt   = r_sweep_cnt;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pbit_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pbit_sweep_ctrl
//  Brief    : Directed scoreboard bench for pbit_sweep_ctrl (HOLD_CYC=1 and 0).
//  Revision : 1.0
// ============================================================================
module tb_pbit_sweep_ctrl;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    pbit_sweep_ctrl_if #(.IDX_W(4), .LFSR_W(12)) ifa ();
    pbit_sweep_ctrl_if #(.IDX_W(4), .LFSR_W(12)) ifb ();

    pbit_sweep_ctrl #(.N_PBITS(16), .IDX_W(4), .LFSR_W(12), .SETTLE_CYC(2), .HOLD_CYC(1)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ifa.slave)
    );

    pbit_sweep_ctrl #(.N_PBITS(16), .IDX_W(4), .LFSR_W(12), .SETTLE_CYC(2), .HOLD_CYC(0)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb.slave)
    );

    typedef struct { int t; int sel; int sw; } ev_t;
    typedef struct {
        logic        load;
        logic [11:0] lseed;
        logic        en;
        logic        upd;
        logic [3:0]  sel;
        logic [15:0] scnt;
        logic        busy;
        logic        done;
    } obs_t;

    ev_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic obs_t sample(input bit use_b);
        obs_t o;
        if (use_b) begin
            o.load = ifb.lfsr_load; o.lseed = ifb.lfsr_seed; o.en = ifb.lfsr_en;
            o.upd = ifb.pbit_update; o.sel = ifb.pbit_sel; o.scnt = ifb.sweep_cnt;
            o.busy = ifb.busy; o.done = ifb.done;
        end else begin
            o.load = ifa.lfsr_load; o.lseed = ifa.lfsr_seed; o.en = ifa.lfsr_en;
            o.upd = ifa.pbit_update; o.sel = ifa.pbit_sel; o.scnt = ifa.sweep_cnt;
            o.busy = ifa.busy; o.done = ifa.done;
        end
        return o;
    endfunction

    task automatic drive(input bit use_b, input logic st, input logic ab,
                         input logic [15:0] n, input logic [11:0] s);
        if (use_b) begin
            ifb.start = st; ifb.abort = ab; ifb.num_sweeps = n; ifb.seed = s;
        end else begin
            ifa.start = st; ifa.abort = ab; ifa.num_sweeps = n; ifa.seed = s;
        end
    endtask

    task automatic chk_reset(input bit use_b);
        obs_t o = sample(use_b);
        chk("rst_load", 32'(o.load), 0);
        chk("rst_seed", 32'(o.lseed), 0);
        chk("rst_en", 32'(o.en), 0);
        chk("rst_upd", 32'(o.upd), 0);
        chk("rst_sel", 32'(o.sel), 0);
        chk("rst_scnt", 32'(o.scnt), 0);
        chk("rst_busy", 32'(o.busy), 0);
        chk("rst_done", 32'(o.done), 0);
    endtask

    // Called at a negedge with the DUT idle. abort_at / ign_at are strobe indices (-1 = unused).
    task automatic run(input bit use_b, input int nsw, input logic [11:0] sd,
                       input int abort_at, input int ign_at, input bit abort_with_start);
        int          hold = use_b ? 0 : 1;
        int          n_str = (abort_at >= 0) ? abort_at + 1 : 16 * nsw;
        int          t_fin = (nsw == 0) ? 1 : 4 + (1 + hold) * 16 * nsw;
        int          t_end_exp = (abort_at >= 0) ? 4 + (1 + hold) * abort_at + 1 : t_fin + 1;
        int          t_done = -1;
        int          t_end = -1;
        int          loads = 0;
        int          en_pre = 0;
        int          k = 0;
        logic [15:0] cur_n = 16'(nsw);
        logic [11:0] cur_s = sd;
        obs_t        o;
        ev_t         e;
        sb.delete();
        for (int j = 0; j < n_str; j++) begin
            e.t = 4 + (1 + hold) * j; e.sel = j % 16; e.sw = j / 16;
            sb.push_back(e);
        end
        drive(use_b, 1'b1, abort_with_start, cur_n, cur_s);
        for (int t = 1; t <= t_end_exp + 20; t++) begin
            @(negedge clk);
            drive(use_b, 1'b0, 1'b0, cur_n, cur_s);
            o = sample(use_b);
            if (!o.busy) begin
                t_end = t;
                chk("exit_upd", 32'(o.upd), 0);
                chk("exit_en", 32'(o.en), 0);
                chk("exit_load", 32'(o.load), 0);
                break;
            end
            if (o.load) begin
                loads++;
                chk("load_seed", 32'(o.lseed), 32'(sd));
                chk("load_en", 32'(o.en), 0);
            end
            if (o.en && !o.upd && k == 0) en_pre++;
            if (o.done) begin
                t_done = t;
                chk("done_en", 32'(o.en), 0);
            end
            if (o.upd) begin
                if (sb.size() == 0) begin
                    chk("extra_strobe", 32'(t), 0);
                end else begin
                    e = sb.pop_front();
                    chk("strobe_sel", 32'(o.sel), 32'(e.sel));
                    chk("strobe_time", 32'(t), 32'(e.t));
                    chk("strobe_scnt", 32'(o.scnt), 32'(e.sw));
                    chk("strobe_en", 32'(o.en), 1);
                end
                if (k == abort_at) drive(use_b, 1'b0, 1'b1, cur_n, cur_s);
                if (k == ign_at) begin
                    cur_n = 16'd9; cur_s = ~sd;
                    drive(use_b, 1'b1, 1'b0, cur_n, cur_s);
                end
                k++;
            end
        end
        chk("end_time", 32'(t_end), 32'(t_end_exp));
        chk("strobes_left", 32'(sb.size()), 0);
        chk("load_count", 32'(loads), (nsw != 0) ? 1 : 0);
        chk("settle_cycles", 32'(en_pre), (nsw != 0) ? 2 : 0);
        chk("done_time", 32'(t_done), (abort_at >= 0) ? 32'hFFFF_FFFF : 32'(t_fin));
        o = sample(use_b);
        chk("final_scnt", 32'(o.scnt), (abort_at >= 0) ? 32'(abort_at / 16) : 32'(nsw));
        chk("final_seed", 32'(o.lseed), 32'(sd));
        chk("final_done", 32'(o.done), 0);
    endtask

    initial begin : main
        obs_t o;
        bit   hit;
        drive(1'b0, 1'b0, 1'b0, 16'd0, 12'd0);
        drive(1'b1, 1'b0, 1'b0, 16'd0, 12'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset(1'b0);
        chk_reset(1'b1);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);

        run(1'b0, 1, 12'hDA5, -1, -1, 1'b0);
        run(1'b0, 3, 12'h123, -1, -1, 1'b0);
        run(1'b0, 0, 12'h3C3, -1, -1, 1'b0);
        run(1'b0, 2, 12'h5A5, 4, -1, 1'b0);
        run(1'b0, 1, 12'h777, -1, -1, 1'b0);
        run(1'b0, 2, 12'hABC, -1, 10, 1'b0);
        run(1'b0, 1, 12'h0F1, -1, -1, 1'b1);

        // Abort while idle must not disturb anything.
        drive(1'b0, 1'b0, 1'b1, 16'd1, 12'h0F1);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 16'd1, 12'h0F1);
        o = sample(1'b0);
        chk("idle_abort_busy", 32'(o.busy), 0);
        chk("idle_abort_scnt", 32'(o.scnt), 1);
        chk("idle_abort_load", 32'(o.load), 0);

        run(1'b1, 2, 12'h9E2, -1, -1, 1'b0);

        // Reset asserted while dut_b sits in UPDATE with pbit_sel=5.
        drive(1'b1, 1'b1, 1'b0, 16'd2, 12'h456);
        hit = 1'b0;
        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 1'b0, 16'd2, 12'h456);
            o = sample(1'b1);
            if (o.upd && o.sel == 4'd5) begin
                hit = 1'b1;
                break;
            end
        end
        chk("midrun_reached", 32'(hit), 1);
        rst_b = 1'b1;
        @(negedge clk);
        chk_reset(1'b1);
        rst_b = 1'b0;
        @(negedge clk);
        run(1'b1, 1, 12'h321, -1, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
